mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the single-cycle MEM-stage memory access wrapper. Sits in MEM between EX/MEM and MEM/WB registers. Handles RV32 byte/halfword/word loads and stores with lane steering and sign/zero extension. Talks to the data memory over a req/gnt/rvalid handshake with variable latency and a bus timeout, and stalls the pipeline while an access is outstanding.

Parameters:
ADDR_W, 32, width of byte address and dm_addr
MAX_WAIT, 15, max cycles in REQ+WAIT before bus-error abort (>=1)
TIMEOUT_EN, 1, 0 disables timeout counter (wait forever)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
ex_valid  in  1  MEM-stage instruction valid
mem_read  in  1  load request
mem_write  in  1  store request; wins if both high (read ignored)
funct3  in  3  RV32 width/sign code
addr  in  ADDR_W  byte address (ALU result)
store_data  in  32  store operand (rs2)
stall  out  1  hold upstream pipeline
wb_valid  out  1  one-cycle pulse: access completed OK
wb_data  out  32  extended load data (0 for stores)
exc_misaligned  out  1  misaligned or unsupported funct3
exc_bus  out  1  one-cycle pulse: timeout abort
dm_req  out  1  memory request
dm_we  out  1  write enable
dm_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
dm_be  out  4  byte enables
dm_wdata  out  32  lane-replicated write data
dm_gnt  in  1  request accepted
dm_rvalid  in  1  read data valid
dm_rdata  in  32  read word

Behaviour:
- Reset (async, resetn low): state IDLE; dm_req/dm_we/dm_be/dm_addr/dm_wdata, wb_valid, wb_data, exc_bus = 0; stall and exc_misaligned forced 0 while resetn low. Reset mid-access drops dm_req immediately; in-flight rvalid afterwards ignored.
- funct3: loads LB=0, LH=1, LW=2, LBU=4, LHU=5; stores SB=0, SH=1, SW=2. Any other code = unsupported.
- start = IDLE & ex_valid & (mem_read|mem_write).
- Fault check (combinational, IDLE): halfword with addr[0]=1, word with addr[1:0]!=0, or unsupported funct3 -> exc_misaligned=1 same cycle, stall=0, no bus request, no state change.
- FSM: IDLE, REQ, WAIT, DONE.
  - IDLE: on start & no fault, latch dm_addr, dm_we, dm_be, dm_wdata, funct3, addr[1:0]; -> REQ; stall=1.
  - REQ: dm_req=1, outputs held stable until dm_gnt. On gnt: store -> DONE; load -> WAIT. stall=1.
  - WAIT: on dm_rvalid capture aligned/extended data into wb_data -> DONE. stall=1. rvalid earliest the cycle after gnt.
  - DONE: wb_valid=1 (unless aborted), stall=0, -> IDLE unconditionally; inputs ignored (same instruction still present).
- Latency: store accept->wb_valid = 2 cycles with gnt in first REQ cycle; load = 3 with gnt and rvalid at earliest.
- Timeout (TIMEOUT_EN=1): counter clears on IDLE exit, increments each REQ/WAIT cycle; when it reaches MAX_WAIT without completion -> drop dm_req, DONE with exc_bus=1, wb_valid=0, wb_data=0. Completion in the same cycle as expiry wins.
- Store lanes: SB be=0001<<addr[1:0], data byte replicated x4; SH be=0011<<addr[1:0], half replicated x2; SW be=1111.
- Load extract: shift dm_rdata right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- dm_be=0 and dm_req=0 outside REQ.

Decomposition:
- mem_access_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum typedef mem_state_t {IDLE,REQ,WAIT,DONE}.
- Sub-module load_aligner: combinational rdata+offset+funct3 -> extended 32-bit word; reused by the bench reference model.

Test Plan:
- SW addr=0x100 data=0xDEADBEEF, gnt in first REQ cycle -> dm_be=1111, dm_addr=0x100, stall 2 cycles, wb_valid pulse cycle 2.
- SB addr=0x103 data=0x000000A5 -> dm_be=1000, dm_wdata=0xA5A5A5A5.
- LB addr=0x102, rdata=0x12F45678 -> wb_data=0xFFFFFFF4; LBU same -> 0x000000F4; LHU addr=0x102 -> 0x000012F4.
- LW addr=0x101 -> exc_misaligned=1 same cycle, stall=0, dm_req never asserted; funct3=3 load -> same.
- Load, gnt after 3 cycles, rvalid withheld, MAX_WAIT=15 -> exc_bus pulse, wb_valid=0, dm_req low, FSM back to IDLE.
- Assert resetn low during WAIT, then rvalid -> all outputs 0, no wb_valid; next access behaves normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage memory access unit: funct3 codes, FSM states
// and the store lane-steering helpers.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // size is funct3[1:0]: 0 byte, 1 half, anything else word
    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        unique case (size)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the operand across lanes so the byte enables alone pick the target bytes
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        unique case (size)
            2'd0:    wd = {4{data[7:0]}};
            2'd1:    wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the data memory (slave).
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_be;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_aligner.sv
// Combinational load extractor: shifts the addressed lane down and sign/zero extends.
module load_aligner
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        unique case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = 32'd0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane steering, extension, req/gnt/rvalid handshake with a
// bus timeout, and pipeline stall while an access is outstanding.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MAX_WAIT   = 15,
    parameter bit          TIMEOUT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic              exc_misaligned,
    output logic              exc_bus,
    mem_access_unit_if.master dm
);
    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              abort_q, abort_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic        start, f3_ok, misal, fault, accept, expire;
    logic [31:0] load_ext;

    load_aligner u_load_aligner (
        .rdata  (dm.dm_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_ext)
    );

    always_comb begin
        start = (state_q == IDLE) && ex_valid && (mem_read || mem_write);
        if (mem_write) begin
            f3_ok = funct3 inside {F3_B, F3_H, F3_W};
        end else begin
            f3_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
        misal  = ((funct3[1:0] == 2'd1) && addr[0]) ||
                 ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'd0));
        fault  = !f3_ok || misal;
        accept = start && !fault;
        // Fires on the MAX_WAIT-th cycle spent in REQ+WAIT
        expire = TIMEOUT_EN && (cnt_q == CntW'(MAX_WAIT - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            wb_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = REQ;
                    addr_d    = {addr[ADDR_W-1:2], 2'b00};
                    we_d      = mem_write;
                    be_d      = calc_be(funct3[1:0], addr[1:0]);
                    wdata_d   = mem_write ? calc_wdata(funct3[1:0], store_data) : 32'd0;
                    f3_d      = funct3;
                    off_d     = addr[1:0];
                    cnt_d     = '0;
                    abort_d   = 1'b0;
                    wb_data_d = 32'd0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CntW'(1);
                if (dm.dm_gnt && we_q) begin
                    state_d = DONE;
                end else if (expire) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                end else if (dm.dm_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                if (dm.dm_rvalid) begin
                    state_d   = DONE;
                    wb_data_d = load_ext;
                end else if (expire) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dm.dm_req      = (state_q == REQ);
        dm.dm_we       = (state_q == REQ) && we_q;
        dm.dm_be       = (state_q == REQ) ? be_q : 4'd0;
        dm.dm_addr     = addr_q;
        dm.dm_wdata    = wdata_q;
        wb_valid       = (state_q == DONE) && !abort_q;
        exc_bus        = (state_q == DONE) && abort_q;
        wb_data        = wb_data_q;
        exc_misaligned = resetn && start && fault;
        unique case (state_q)
            IDLE:      stall = accept;
            REQ, WAIT: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
        stall = stall && resetn;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, faults, timeout and reset mid-access.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, wb_valid, exc_misaligned, exc_bus;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    // Per-access observations
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_wbdata;
    logic        o_we, o_wbv, o_excbus, o_req_at_done, o_stable;
    int          o_stall_cycles, o_done_cyc;

    mem_access_unit_if #(.ADDR_W(32)) dm_if ();

    mem_access_unit #(
        .ADDR_W     (32),
        .MAX_WAIT   (15),
        .TIMEOUT_EN (1'b1)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ex_valid       (ex_valid),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .exc_misaligned (exc_misaligned),
        .exc_bus        (exc_bus),
        .dm             (dm_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dm_if.dm_gnt    = 1'b0;
        dm_if.dm_rvalid = 1'b0;
    endtask

    // rv_dly < 0 means rvalid is never returned
    task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd);
        int cyc, req_cnt, gnt_cyc;
        bit captured, done;
        cyc = 0; req_cnt = 0; gnt_cyc = -1; captured = 0; done = 0;
        o_stall_cycles = 0; o_done_cyc = -1; o_wbv = 0; o_excbus = 0;
        o_wbdata = 32'hxxxxxxxx; o_req_at_done = 1'bx; o_stable = 1;
        o_be = 4'hx; o_addr = 32'hx; o_wdata = 32'hx; o_we = 1'bx;
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_write = we; mem_read = !we;
        funct3 = f3; addr = a; store_data = wd; dm_if.dm_rdata = rd;
        while (cyc < 64 && !done) begin
            dm_if.dm_gnt    = dm_if.dm_req && (req_cnt == gnt_dly);
            dm_if.dm_rvalid = (gnt_cyc >= 0) && (rv_dly >= 0) && (cyc - gnt_cyc - 1 == rv_dly);
            @(negedge clk);
            if (stall) o_stall_cycles++;
            if (dm_if.dm_req) begin
                if (!captured) begin
                    o_be = dm_if.dm_be; o_addr = dm_if.dm_addr;
                    o_wdata = dm_if.dm_wdata; o_we = dm_if.dm_we;
                    captured = 1;
                end else if (o_be !== dm_if.dm_be || o_addr !== dm_if.dm_addr) begin
                    o_stable = 0;
                end
                if (dm_if.dm_gnt) gnt_cyc = cyc;
                req_cnt++;
            end
            if (wb_valid || exc_bus) begin
                done = 1; o_done_cyc = cyc;
                o_wbv = wb_valid; o_excbus = exc_bus; o_wbdata = wb_data;
                o_req_at_done = dm_if.dm_req;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic chk_fault(input string tag, input bit we, input logic [2:0] f3,
                             input logic [31:0] a);
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_write = we; mem_read = !we; funct3 = f3; addr = a;
        store_data = 32'h1234_5678;
        #1;
        check({tag, "_exc_same_cycle"}, {31'd0, exc_misaligned}, 32'd1);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_no_req"}, {31'd0, dm_if.dm_req}, 32'd0);
        check({tag, "_exc_held"}, {31'd0, exc_misaligned}, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check({tag, "_exc_clear"}, {31'd0, exc_misaligned}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; dm_if.dm_rdata = 32'd0;
        resetn = 1'b0;
        ex_valid = 1'b1; mem_write = 1'b1;
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, dm_if.dm_req}, 32'd0);
        check("rst_be", {28'd0, dm_if.dm_be}, 32'd0);
        check("rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("rst_wbdata", wb_data, 32'd0);
        check("rst_excbus", {31'd0, exc_bus}, 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // SW aligned, immediate grant
        run_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, -1, 32'd0);
        check("sw_be", {28'd0, o_be}, 32'h0000000F);
        check("sw_addr", o_addr, 32'h100);
        check("sw_wdata", o_wdata, 32'hDEADBEEF);
        check("sw_we", {31'd0, o_we}, 32'd1);
        check("sw_stall_cycles", o_stall_cycles, 2);
        check("sw_done_cyc", o_done_cyc, 2);
        check("sw_wbv", {31'd0, o_wbv}, 32'd1);
        check("sw_wbdata", o_wbdata, 32'd0);
        @(negedge clk);
        check("sw_wbv_pulse", {31'd0, wb_valid}, 32'd0);

        // SB to lane 3
        run_op(1'b1, 3'd0, 32'h103, 32'h000000A5, 0, -1, 32'd0);
        check("sb_be", {28'd0, o_be}, 32'h00000008);
        check("sb_wdata", o_wdata, 32'hA5A5A5A5);
        check("sb_addr", o_addr, 32'h100);

        // SH to upper half
        run_op(1'b1, 3'd1, 32'h102, 32'h1234BEEF, 0, -1, 32'd0);
        check("sh_be", {28'd0, o_be}, 32'h0000000C);
        check("sh_wdata", o_wdata, 32'hBEEFBEEF);

        // Loads with earliest grant and rvalid
        run_op(1'b0, 3'd0, 32'h102, 32'd0, 0, 0, 32'h12F45678);
        check("lb_data", o_wbdata, 32'hFFFFFFF4);
        check("lb_done_cyc", o_done_cyc, 3);
        check("lb_stall_cycles", o_stall_cycles, 3);
        check("lb_we", {31'd0, o_we}, 32'd0);
        check("lb_be", {28'd0, o_be}, 32'h00000004);
        run_op(1'b0, 3'd4, 32'h102, 32'd0, 0, 0, 32'h12F45678);
        check("lbu_data", o_wbdata, 32'h000000F4);
        run_op(1'b0, 3'd5, 32'h102, 32'd0, 0, 0, 32'h12F45678);
        check("lhu_data", o_wbdata, 32'h000012F4);
        run_op(1'b0, 3'd1, 32'h102, 32'd0, 0, 0, 32'h80010000);
        check("lh_data", o_wbdata, 32'hFFFF8001);

        // LW with slow grant and slow rvalid
        run_op(1'b0, 3'd2, 32'h204, 32'd0, 2, 3, 32'hCAFEF00D);
        check("lw_slow_data", o_wbdata, 32'hCAFEF00D);
        check("lw_slow_addr", o_addr, 32'h204);
        check("lw_slow_done_cyc", o_done_cyc, 8);
        check("lw_slow_wbv", {31'd0, o_wbv}, 32'd1);

        // Faults
        chk_fault("lw_mis", 1'b0, 3'd2, 32'h101);
        chk_fault("f3_3", 1'b0, 3'd3, 32'h100);
        chk_fault("sh_mis", 1'b1, 3'd1, 32'h101);
        chk_fault("sbu_store", 1'b1, 3'd4, 32'h100);

        // Timeout: grant after 3 waiting cycles, rvalid withheld
        run_op(1'b0, 3'd2, 32'h300, 32'd0, 3, -1, 32'h0);
        check("to_excbus", {31'd0, o_excbus}, 32'd1);
        check("to_wbv", {31'd0, o_wbv}, 32'd0);
        check("to_wbdata", o_wbdata, 32'd0);
        check("to_req_low", {31'd0, o_req_at_done}, 32'd0);
        check("to_done_cyc", o_done_cyc, 16);
        check("to_stall_cycles", o_stall_cycles, 16);
        check("to_req_stable", {31'd0, o_stable}, 32'd1);
        @(negedge clk);
        check("to_excbus_pulse", {31'd0, exc_bus}, 32'd0);
        check("to_idle_stall", {31'd0, stall}, 32'd0);

        // Reset while waiting for read data
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h400;
        @(posedge clk); #1;
        dm_if.dm_gnt = 1'b1;
        @(posedge clk); #1;
        dm_if.dm_gnt = 1'b0;
        check("rw_stall_in_wait", {31'd0, stall}, 32'd1);
        resetn = 1'b0;
        ex_valid = 1'b0; mem_read = 1'b0;
        #1;
        check("rw_stall", {31'd0, stall}, 32'd0);
        check("rw_addr", dm_if.dm_addr, 32'd0);
        check("rw_req", {31'd0, dm_if.dm_req}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        dm_if.dm_rvalid = 1'b1; dm_if.dm_rdata = 32'h55AA55AA;
        @(negedge clk);
        check("rw_no_wbv", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        dm_if.dm_rvalid = 1'b0;
        @(negedge clk);
        check("rw_no_wbv_late", {31'd0, wb_valid}, 32'd0);
        check("rw_wbdata", wb_data, 32'd0);
        run_op(1'b0, 3'd4, 32'h103, 32'd0, 0, 0, 32'h80FFFFFF);
        check("rw_after_lbu", o_wbdata, 32'h00000080);
        check("rw_after_done", o_done_cyc, 3);
        run_op(1'b0, 3'd0, 32'h103, 32'd0, 1, 1, 32'h80FFFFFF);
        check("rw_after_lb", o_wbdata, 32'hFFFFFF80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
